// File: rtl/start_sequencer.sv
// Batch launcher for a downstream core: issues num_runs start pulses, each
// gated on the previous core_done, with a per-run watchdog that latches timeout.
module start_sequencer #(
    parameter int RUNS_W  = 8,
    parameter int TIMEOUT = 512,
    parameter int TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [RUNS_W-1:0] num_runs,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [RUNS_W-1:0] runs_done
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP,
        FINISH,
        ERROR
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [RUNS_W-1:0] target;
    logic [TO_W-1:0]   wd;
    logic [RUNS_W-1:0] runs_inc;
    logic              accept;
    logic              complete;
    logic              expire;

    assign runs_inc = runs_done + 1'b1;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        complete = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE, ERROR: begin
                if (go) begin
                    accept   = 1'b1;
                    state_nx = (num_runs == '0) ? FINISH : LAUNCH;
                end
            end
            LAUNCH: state_nx = WAIT;
            WAIT: begin
                // A completion on the last watchdog cycle still wins over the timeout.
                if (core_done) begin
                    complete = 1'b1;
                    state_nx = (runs_inc == target) ? FINISH : GAP;
                end else if (wd == WD_LAST) begin
                    expire   = 1'b1;
                    state_nx = ERROR;
                end
            end
            GAP:     state_nx = LAUNCH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            target    <= '0;
            runs_done <= '0;
            wd        <= '0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                target    <= num_runs;
                runs_done <= '0;
                timeout   <= 1'b0;
            end
            if (state == LAUNCH) begin
                wd <= '0;
            end else if (state == WAIT && !core_done && !expire) begin
                wd <= wd + 1'b1;
            end
            if (complete) begin
                runs_done <= runs_inc;
            end
            if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

    assign core_start = (state == LAUNCH);
    assign done       = (state == FINISH);
    assign busy       = (state == LAUNCH) || (state == WAIT) ||
                        (state == GAP)    || (state == FINISH);

endmodule

// File: tb/tb_start_sequencer.sv
// Directed bench for start_sequencer: a vector table for the per-cycle
// protocol plus hand-written multi-cycle sequences.
module tb_start_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // main instance, short watchdog
    logic       go = 1'b0;
    logic [7:0] num_runs = 8'd0;
    logic       core_done = 1'b0;
    logic       core_start, busy, done, timeout;
    logic [7:0] runs_done;

    // default-parameter instance for the long single run
    logic       go_b = 1'b0;
    logic [7:0] num_runs_b = 8'd0;
    logic       core_done_b = 1'b0;
    logic       core_start_b, busy_b, done_b, timeout_b;
    logic [7:0] runs_done_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    start_sequencer #(.RUNS_W(8), .TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .go(go), .num_runs(num_runs),
        .core_start(core_start), .core_done(core_done), .busy(busy),
        .done(done), .timeout(timeout), .runs_done(runs_done)
    );

    start_sequencer dut_b (
        .clk(clk), .rst(rst), .go(go_b), .num_runs(num_runs_b),
        .core_start(core_start_b), .core_done(core_done_b), .busy(busy_b),
        .done(done_b), .timeout(timeout_b), .runs_done(runs_done_b)
    );

    typedef struct {
        logic       go;
        logic [7:0] n;
        logic       cd;
        logic       cs;
        logic       b;
        logic       d;
        logic       t;
        logic [7:0] rd;
        logic       chk_rd;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int starts, dones, cnt, gap_bad, prev_cs, cyc, maxrd, tbound;
        logic seen_to;

        tbl[0]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[1]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[2]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[3]  = '{1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[4]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[5]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[6]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[7]  = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1};
        tbl[8]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1};
        tbl[9]  = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};
        tbl[10] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};

        // reset state
        #12;
        chk("rst_core_start", core_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_runs_done", runs_done, 0);
        chk("rst_busy_b", busy_b, 0);
        @(negedge clk);
        rst = 1'b1;

        // single run on default instance, core_done 20 cycles after start
        go_b = 1'b1; num_runs_b = 8'd1;
        tick();
        go_b = 1'b0;
        chk("single_start", core_start_b, 1);
        starts = 1; dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (core_start_b) starts++;
            if (done_b) dones++;
        end
        core_done_b = 1'b1;
        tick();
        core_done_b = 1'b0;
        chk("single_starts", starts, 1);
        chk("single_early_done", dones, 0);
        chk("single_done", done_b, 1);
        chk("single_runs_done", runs_done_b, 1);
        chk("single_timeout", timeout_b, 0);
        tick();
        chk("single_done_pulse", done_b, 0);
        chk("single_busy_after", busy_b, 0);

        // per-cycle protocol table
        foreach (tbl[i]) begin
            go = tbl[i].go; num_runs = tbl[i].n; core_done = tbl[i].cd;
            tick();
            chk($sformatf("vec%0d_core_start", i), core_start, tbl[i].cs);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].b);
            chk($sformatf("vec%0d_done", i), done, tbl[i].d);
            chk($sformatf("vec%0d_timeout", i), timeout, tbl[i].t);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d_runs_done", i), runs_done, tbl[i].rd);
        end
        go = 1'b0; num_runs = 8'd0; core_done = 1'b0;

        // batch of 3, core_done 5 cycles after each start
        go = 1'b1; num_runs = 8'd3;
        tick();
        go = 1'b0;
        starts = 0; dones = 0; cnt = -1; gap_bad = 0; prev_cs = 0;
        for (int c = 0; c < 100 && dones == 0; c++) begin
            if (core_start) begin
                starts++;
                if (prev_cs) gap_bad++;
                cnt = 0;
            end else if (cnt >= 0) begin
                cnt++;
            end
            if (done) dones++;
            prev_cs = core_start;
            core_done = (cnt == 5);
            if (cnt == 5) cnt = -1;
            if (dones == 0) tick();
        end
        core_done = 1'b0;
        chk("batch_starts", starts, 3);
        chk("batch_gap", gap_bad, 0);
        chk("batch_done", dones, 1);
        chk("batch_runs_done", runs_done, 3);
        chk("batch_timeout", timeout, 0);
        tick();
        chk("batch_idle", busy, 0);

        // watchdog expiry
        go = 1'b1; num_runs = 8'd1;
        tick();
        go = 1'b0;
        chk("to_start", core_start, 1);
        cyc = 0; dones = 0;
        while (!timeout && cyc < 40) begin
            tick();
            cyc++;
            if (done) dones++;
        end
        chk("to_latency", cyc, 17);
        chk("to_flag", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_no_done", dones, 0);
        chk("to_runs_done", runs_done, 0);
        repeat (3) tick();
        chk("to_sticky", timeout, 1);
        go = 1'b1; num_runs = 8'd1;
        tick();
        go = 1'b0;
        chk("to_clear", timeout, 0);
        chk("to_restart", core_start, 1);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("to_recover_done", done, 1);
        chk("to_recover_runs", runs_done, 1);
        tick();

        // core_done on the last watchdog cycle
        go = 1'b1; num_runs = 8'd1;
        tick();
        go = 1'b0;
        repeat (16) tick();
        chk("edge_no_timeout_yet", timeout, 0);
        chk("edge_still_busy", busy, 1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("edge_done", done, 1);
        chk("edge_timeout", timeout, 0);
        chk("edge_runs_done", runs_done, 1);
        tick();

        // largest target
        go = 1'b1; num_runs = 8'd255;
        tick();
        go = 1'b0;
        starts = 0; dones = 0; prev_cs = 0; maxrd = 0;
        for (int c = 0; c < 1000 && dones == 0; c++) begin
            if (core_start) starts++;
            if (done) dones++;
            if (runs_done > maxrd) maxrd = runs_done;
            core_done = prev_cs[0];
            prev_cs = core_start;
            if (dones == 0) tick();
        end
        core_done = 1'b0;
        chk("max_starts", starts, 255);
        chk("max_done", dones, 1);
        chk("max_runs_done", runs_done, 255);
        chk("max_peak", maxrd, 255);
        tick();
        tick();
        chk("max_hold", runs_done, 255);

        // async reset during WAIT of run 2 of 4
        go = 1'b1; num_runs = 8'd4;
        tick();
        go = 1'b0;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        tick();
        tick();
        chk("mid_runs_before", runs_done, 1);
        chk("mid_busy_before", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_core_start", core_start, 0);
        chk("mid_done", done, 0);
        chk("mid_timeout", timeout, 0);
        chk("mid_runs_done", runs_done, 0);
        dones = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done || busy) dones++;
        end
        chk("mid_quiet", dones, 0);
        rst = 1'b1;
        go = 1'b1; num_runs = 8'd1;
        tick();
        go = 1'b0;
        chk("post_rst_go", core_start, 1);
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("post_rst_done", done, 1);
        chk("post_rst_runs", runs_done, 1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
